// File: rtl/alu_pkg.sv
// Shared types, canonical control codes and a reference model for the Hack-style ALU.
package alu_pkg;

  localparam int ALU_REF_WIDTH = 16;
  localparam int ALU_CTRL_BITS = 6;

  // Field order matches the textbook {zx,nx,zy,ny,f,no} code, zx in the MSB.
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  localparam alu_ctrl_t ALU_ZERO      = 6'b101010;
  localparam alu_ctrl_t ALU_ONE       = 6'b111111;
  localparam alu_ctrl_t ALU_NEG1      = 6'b111010;
  localparam alu_ctrl_t ALU_X         = 6'b001100;
  localparam alu_ctrl_t ALU_Y         = 6'b110000;
  localparam alu_ctrl_t ALU_NOT_X     = 6'b001101;
  localparam alu_ctrl_t ALU_NOT_Y     = 6'b110001;
  localparam alu_ctrl_t ALU_NEG_X     = 6'b001111;
  localparam alu_ctrl_t ALU_NEG_Y     = 6'b110011;
  localparam alu_ctrl_t ALU_X_PLUS_1  = 6'b011111;
  localparam alu_ctrl_t ALU_Y_PLUS_1  = 6'b110111;
  localparam alu_ctrl_t ALU_X_MINUS_1 = 6'b001110;
  localparam alu_ctrl_t ALU_Y_MINUS_1 = 6'b110010;
  localparam alu_ctrl_t ALU_X_PLUS_Y  = 6'b000010;
  localparam alu_ctrl_t ALU_X_MINUS_Y = 6'b010011;
  localparam alu_ctrl_t ALU_Y_MINUS_X = 6'b000111;
  localparam alu_ctrl_t ALU_X_AND_Y   = 6'b000000;
  localparam alu_ctrl_t ALU_X_OR_Y    = 6'b010101;

  // Straight-line model of the conditioning pipeline at the default width.
  function automatic logic [ALU_REF_WIDTH-1:0] alu_ref(
    input logic [ALU_REF_WIDTH-1:0] x,
    input logic [ALU_REF_WIDTH-1:0] y,
    input alu_ctrl_t                c
  );
    logic [ALU_REF_WIDTH-1:0] xa;
    logic [ALU_REF_WIDTH-1:0] ya;
    logic [ALU_REF_WIDTH-1:0] r;
    xa = c.zx ? '0 : x;
    if (c.nx) xa = ~xa;
    ya = c.zy ? '0 : y;
    if (c.ny) ya = ~ya;
    r = c.f ? (xa + ya) : (xa & ya);
    if (c.no) r = ~r;
    return r;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: operand zero/invert, add-or-and select, result invert.
// Zero latency, no flow control.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]         x,
  input  logic [WIDTH-1:0]         y,
  input  logic [ALU_CTRL_BITS-1:0] ctrl,
  output logic [WIDTH-1:0]         res
);

  alu_ctrl_t        c;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] x2;
  logic [WIDTH-1:0] y1;
  logic [WIDTH-1:0] y2;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] conj;
  logic [WIDTH-1:0] r;

  assign c = alu_ctrl_t'(ctrl);

  assign x1 = c.zx ? '0 : x;
  assign x2 = c.nx ? ~x1 : x1;
  assign y1 = c.zy ? '0 : y;
  assign y2 = c.ny ? ~y1 : y1;

  // Carry-out is intentionally dropped: arithmetic is modulo 2^WIDTH.
  assign sum  = x2 + y2;
  assign conj = x2 & y2;
  assign r    = c.f ? sum : conj;
  assign res  = c.no ? ~r : r;

endmodule

// File: rtl/alu.sv
// Registered Hack ALU with zero/negative flags; 1-cycle latency, one op per cycle.
// No backpressure: every in_valid beat is accepted and produced the next cycle.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             out_valid
);

  alu_ctrl_t        ctrl;
  logic [WIDTH-1:0] res;

  assign ctrl = '{zx: zx, nx: nx, zy: zy, ny: ny, f: f, no: no};

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .x    (x),
    .y    (y),
    .ctrl (ctrl),
    .res  (res)
  );

  // Flags are registered alongside out so they always describe the held value.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      zr        <= 1'b1;
      ng        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= res;
        zr  <= (res == '0);
        ng  <= res[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed vectors push expectations, a negedge monitor pops and compares.
module tb_alu;
  import alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         zx, nx, zy, ny, f, no;
  logic         in_valid;
  logic [W-1:0] out;
  logic         zr, ng, out_valid;

  alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .y         (y),
    .zx        (zx),
    .nx        (nx),
    .zy        (zy),
    .ny        (ny),
    .f         (f),
    .no        (no),
    .in_valid  (in_valid),
    .out       (out),
    .zr        (zr),
    .ng        (ng),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out;
    logic         zr;
    logic         ng;
    int           cyc;
    int           tag;
  } exp_t;

  typedef struct {
    alu_ctrl_t    c;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] res;
  } vec_t;

  exp_t         sb[$];
  int           checks = 0;
  int           passes = 0;
  int           cyc = 0;
  bit           mon_en = 1'b0;
  logic [W-1:0] last_out = '0;
  logic         last_zr = 1'b1;
  logic         last_ng = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, tag, act, req);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", cyc, 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", e.tag, 32'(cyc), 32'(e.cyc + 1));
          chk("out", e.tag, 32'(out), 32'(e.out));
          chk("zr", e.tag, 32'(zr), 32'(e.zr));
          chk("ng", e.tag, 32'(ng), 32'(e.ng));
          last_out = e.out;
          last_zr  = e.zr;
          last_ng  = e.ng;
        end
      end else begin
        chk("hold_out", cyc, 32'(out), 32'(last_out));
        chk("hold_zr", cyc, 32'(zr), 32'(last_zr));
        chk("hold_ng", cyc, 32'(ng), 32'(last_ng));
      end
    end
  end

  task automatic issue(input alu_ctrl_t c, input logic [W-1:0] xv, input logic [W-1:0] yv,
                       input logic [W-1:0] res, input int tag);
    exp_t e;
    {zx, nx, zy, ny, f, no} = c;
    x        = xv;
    y        = yv;
    in_valid = 1'b1;
    e.out = res;
    e.zr  = (res == '0);
    e.ng  = res[W-1];
    e.cyc = cyc;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Hand-computed vectors; zr/ng follow from the expected result.
  vec_t vecs[21] = '{
    '{ALU_ZERO,      16'hAAAA, 16'h5555, 16'h0000},
    '{ALU_ONE,       16'hAAAA, 16'h5555, 16'h0001},
    '{ALU_NEG1,      16'hAAAA, 16'h5555, 16'hFFFF},
    '{ALU_X,         16'hAAAA, 16'h5555, 16'hAAAA},
    '{ALU_Y,         16'hAAAA, 16'h5555, 16'h5555},
    '{ALU_NOT_X,     16'hAAAA, 16'h5555, 16'h5555},
    '{ALU_NOT_Y,     16'hAAAA, 16'h5555, 16'hAAAA},
    '{ALU_NEG_X,     16'hAAAA, 16'h5555, 16'h5556},
    '{ALU_NEG_Y,     16'hAAAA, 16'h5555, 16'hAAAB},
    '{ALU_X_PLUS_1,  16'hAAAA, 16'h5555, 16'hAAAB},
    '{ALU_X_MINUS_1, 16'hAAAA, 16'h5555, 16'hAAA9},
    '{ALU_Y_PLUS_1,  16'hAAAA, 16'h5555, 16'h5556},
    '{ALU_Y_MINUS_1, 16'hAAAA, 16'h5555, 16'h5554},
    '{ALU_X_PLUS_Y,  16'hAAAA, 16'h5555, 16'hFFFF},
    '{ALU_X_MINUS_Y, 16'hAAAA, 16'h5555, 16'h5555},
    '{ALU_Y_MINUS_X, 16'hAAAA, 16'h5555, 16'hAAAB},
    '{ALU_X_AND_Y,   16'hABAA, 16'h5555, 16'h0100},
    '{ALU_X_OR_Y,    16'hAB2A, 16'h5555, 16'hFF7F},
    '{ALU_X_PLUS_Y,  16'h0000, 16'h0000, 16'h0000},
    '{ALU_X_MINUS_Y, 16'h1234, 16'h1235, 16'hFFFF},
    '{ALU_X_PLUS_Y,  16'hFFFF, 16'h0001, 16'h0000}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    x        = 16'hAAAA;
    y        = 16'h5555;
    {zx, nx, zy, ny, f, no} = ALU_X_PLUS_Y;

    // Reset held two cycles with in_valid high: the op must be dropped.
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out", 0, 32'(out), 32'h0000);
    chk("rst_zr", 0, 32'(zr), 32'd1);
    chk("rst_ng", 0, 32'(ng), 32'd0);
    chk("rst_out_valid", 0, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) issue(vecs[i].c, vecs[i].x, vecs[i].y, vecs[i].res, i);

    // Idle with scrambled inputs: outputs must hold the wrapped 0x0000 result.
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      x = W'($urandom);
      y = W'($urandom);
      {zx, nx, zy, ny, f, no} = 6'($urandom);
      @(posedge clk);
      #1;
    end

    // All 64 codes back-to-back against the package model.
    for (int c = 0; c < 64; c++) begin
      logic [W-1:0] xr;
      logic [W-1:0] yr;
      xr = W'($urandom);
      yr = W'($urandom);
      issue(alu_ctrl_t'(c), xr, yr, alu_ref(xr, yr, alu_ctrl_t'(c)), 100 + c);
    end
    in_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
